// File: rtl/flow_sequencer_if.sv
// Instruction-memory fetch and ALU dispatch signals shared by the flow sequencer
// (master) and the memory/ALU side (slave).
interface flow_sequencer_if #(
    parameter int WIDTH = 20,
    parameter int OPW   = 5
);
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_ack;
    logic [WIDTH-1:0] imem_data;

    logic             alu_start;
    logic [OPW-1:0]   alu_op;
    logic             alu_done;
    logic             alu_zero;
    logic             alu_sign;
    logic             alu_carry;

    modport master (
        output imem_req, imem_addr, alu_start, alu_op,
        input  imem_ack, imem_data, alu_done, alu_zero, alu_sign, alu_carry
    );

    modport slave (
        input  imem_req, imem_addr, alu_start, alu_op,
        output imem_ack, imem_data, alu_done, alu_zero, alu_sign, alu_carry
    );
endinterface

// File: rtl/flow_sequencer.sv
// Program-flow front end: owns PP and status, fetches over req/ack, resolves
// flow opcodes locally and hands every other opcode to the ALU units.
module flow_sequencer #(
    parameter int               WIDTH    = 20,
    parameter int               OPW      = 5,
    parameter logic [WIDTH-1:0] RESET_PP = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    flow_sequencer_if.master      bus,
    input  logic                  trap_clear,
    output logic                  trap_mode,
    output logic [WIDTH-1:0]      pp,
    output logic [WIDTH-1:0]      status
);

    localparam logic [OPW-1:0] OP_NOP   = OPW'(0);
    localparam logic [OPW-1:0] OP_TRAP  = OPW'(1);
    localparam logic [OPW-1:0] OP_JMP   = OPW'(2);
    localparam logic [OPW-1:0] OP_JMPZ  = OPW'(3);
    localparam logic [OPW-1:0] OP_JMPS  = OPW'(4);
    localparam logic [OPW-1:0] OP_JMPZS = OPW'(5);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_TARGET,
        S_ALU_WAIT,
        S_TRAP
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pp_q, pp_d;
    logic [OPW-1:0]   op_q, op_d;
    logic [OPW-1:0]   alu_op_q, alu_op_d;
    logic             taken_q, taken_d;
    logic [2:0]       flags_q, flags_d;
    logic             trap_q, trap_d;
    logic             req_c;
    logic             alu_start_c;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_FETCH;
            pp_q     <= RESET_PP;
            op_q     <= '0;
            alu_op_q <= '0;
            taken_q  <= 1'b0;
            flags_q  <= 3'b000;
            trap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pp_q     <= pp_d;
            op_q     <= op_d;
            alu_op_q <= alu_op_d;
            taken_q  <= taken_d;
            flags_q  <= flags_d;
            trap_q   <= trap_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pp_d        = pp_q;
        op_d        = op_q;
        alu_op_d    = alu_op_q;
        taken_d     = taken_q;
        flags_d     = flags_q;
        trap_d      = trap_q;
        req_c       = 1'b0;
        alu_start_c = 1'b0;

        case (state_q)
            S_FETCH: begin
                req_c = 1'b1;
                if (bus.imem_ack) begin
                    op_d    = bus.imem_data[WIDTH-1 -: OPW];
                    pp_d    = pp_q + WIDTH'(1);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // Jump conditions use the flags as they stand now; the target
                // word is only read in the following state.
                case (op_q)
                    OP_NOP: state_d = S_FETCH;
                    OP_TRAP: begin
                        trap_d  = 1'b1;
                        state_d = S_TRAP;
                    end
                    OP_JMP: begin
                        taken_d = 1'b1;
                        state_d = S_TARGET;
                    end
                    OP_JMPZ: begin
                        taken_d = flags_q[0];
                        state_d = S_TARGET;
                    end
                    OP_JMPS: begin
                        taken_d = flags_q[1];
                        state_d = S_TARGET;
                    end
                    OP_JMPZS: begin
                        taken_d = flags_q[0] & flags_q[1];
                        state_d = S_TARGET;
                    end
                    default: begin
                        alu_start_c = 1'b1;
                        alu_op_d    = op_q;
                        state_d     = S_ALU_WAIT;
                    end
                endcase
            end
            S_TARGET: begin
                req_c = 1'b1;
                if (bus.imem_ack) begin
                    pp_d    = taken_q ? bus.imem_data : pp_q + WIDTH'(1);
                    state_d = S_FETCH;
                end
            end
            S_ALU_WAIT: begin
                if (bus.alu_done) begin
                    flags_d = {bus.alu_carry, bus.alu_sign, bus.alu_zero};
                    state_d = S_FETCH;
                end
            end
            S_TRAP: begin
                if (trap_clear) begin
                    trap_d  = 1'b0;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Reset parks the FSM in FETCH, so the request must be masked explicitly
    // to stay low while reset is held.
    assign bus.imem_req  = req_c & ~reset;
    assign bus.imem_addr = pp_q;
    assign bus.alu_start = alu_start_c;
    assign bus.alu_op    = alu_start_c ? op_q : alu_op_q;

    assign trap_mode = trap_q;
    assign pp        = pp_q;
    assign status    = {{(WIDTH-4){1'b0}}, trap_q, flags_q};

endmodule
